// File: rtl/alu_rr_sched_pkg.sv
// Shared definitions for the ALU round-robin scheduler: bus widths, opcodes,
// flag bit positions and FSM state encodings.
package alu_rr_sched_pkg;

  localparam int DW_DEF   = 6;
  localparam int OPW_DEF  = 3;
  localparam int CNTW_DEF = 8;
  localparam int FW       = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;

  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_rr_sched_rr_arb2.sv
// Two-input round-robin arbiter; last_grant resets to 1 so requester 0 wins
// the first contended grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_grant_r;
  logic gnt_valid_s;
  logic gnt_id_s;

  // grant selection: lone requester wins, contention alternates
  always_comb begin
    gnt_valid_s = en & (|req);
    if (req == 2'b11) begin
      gnt_id_s = ~last_grant_r;
    end else if (req[1]) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
  end

  // remember the most recent winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= 1'b1;
    end else if (gnt_valid_s) begin
      last_grant_r <= gnt_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign gnt_valid = gnt_valid_s;
  assign gnt_id    = gnt_id_s;

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one registered ALU between two requesters; issues one operation at a
// time and returns the captured result tagged with the owning requester.
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int OPW  = OPW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic [OPW-1:0]  alu_op,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_c,
  input  logic [FW-1:0]   alu_f,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_c,
  output logic [FW-1:0]   rsp_f,
  output logic            busy,
  output logic [CNTW-1:0] ops_done
);

  state_e          state_r;
  state_e          state_nxt_s;
  logic            gnt_valid_s;
  logic            gnt_id_s;
  logic            req0_ready_s;
  logic            req1_ready_s;
  logic            rsp_hs_s;
  logic [OPW-1:0]  alu_op_r;
  logic [DW-1:0]   alu_a_r;
  logic [DW-1:0]   alu_b_r;
  logic            rsp_valid_r;
  logic            rsp_id_r;
  logic [DW-1:0]   rsp_c_r;
  logic [FW-1:0]   rsp_f_r;
  logic            busy_r;
  logic [CNTW-1:0] ops_done_r;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1_valid, req0_valid}),
    .en        (state_r == ST_IDLE),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // rsp_ready only counts once the response is actually offered in RESP
  assign rsp_hs_s = (state_r == ST_RESP) & rsp_valid_r & rsp_ready;

  // next-state and acceptance pulses
  always_comb begin
    state_nxt_s  = state_r;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_nxt_s  = ST_ISSUE;
          req0_ready_s = ~gnt_id_s;
          req1_ready_s = gnt_id_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_CAPT;
      ST_CAPT:  state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state, ALU operand latch, response capture and completion counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      alu_op_r    <= {OPW{1'b0}};
      alu_a_r     <= {DW{1'b0}};
      alu_b_r     <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_c_r     <= {DW{1'b0}};
      rsp_f_r     <= {FW{1'b0}};
      ops_done_r  <= {CNTW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      if ((state_r == ST_IDLE) && gnt_valid_s) begin
        alu_op_r <= gnt_id_s ? req1_op : req0_op;
        alu_a_r  <= gnt_id_s ? req1_a  : req0_a;
        alu_b_r  <= gnt_id_s ? req1_b  : req0_b;
        rsp_id_r <= gnt_id_s;
      end
      if (state_r == ST_CAPT) begin
        rsp_c_r     <= alu_c;
        rsp_f_r     <= alu_f;
        rsp_valid_r <= 1'b1;
      end else if (rsp_hs_s) begin
        rsp_valid_r <= 1'b0;
        ops_done_r  <= ops_done_r + CNTW'(1);
      end
    end
  end

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign alu_op     = alu_op_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_c      = rsp_c_r;
  assign rsp_f      = rsp_f_r;
  assign busy       = busy_r;
  assign ops_done   = ops_done_r;

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares the single registered ALU between two requesters (req0, req1).
- Accepts one operation at a time over a valid/ready handshake and drives the ALU's OP/A/B inputs.
- Captures the ALU's C/F one cycle after issue and returns them on a shared response channel tagged with the requester ID.
- Sits between the lab top-level (switch/button front-ends) and the ALU instance.

Parameters:
- DW, 6, operand/result width; matches the ALU operand bus.
- OPW, 3, opcode width; matches the ALU opcode bus.
- CNTW, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  one-cycle pulse: req0 operation accepted
- req0_op / req0_a / req0_b  in  OPW/DW/DW  requester 0 opcode and operands
- req1_valid  in  1  requester 1 has an operation pending
- req1_ready  out  1  one-cycle pulse: req1 operation accepted
- req1_op / req1_a / req1_b  in  OPW/DW/DW  requester 1 opcode and operands
- alu_op  out  OPW  registered opcode to ALU OP
- alu_a / alu_b  out  DW  registered operands to ALU A/B
- alu_c  in  DW  ALU result C
- alu_f  in  3  ALU flags F, {carry, overflow, zero}
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that owns the response
- rsp_c  out  DW  captured result
- rsp_f  out  3  captured flags
- busy  out  1  high in every state except IDLE
- ops_done  out  CNTW  count of completed responses; wraps modulo 2^CNTW

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=1 (so req0 wins first).
  - All outputs 0: alu_op/a/b, rsp_*, req*_ready, busy, ops_done.
- FSM states: IDLE -> ISSUE -> CAPT -> RESP -> IDLE.
- IDLE:
  - If exactly one reqN_valid=1: grant N.
  - If both are valid: grant !last_grant.
  - On grant:
    - reqN_ready=1 for this cycle (combinational from state and valids).
    - Latch reqN_op/a/b into alu_op/a/b and the ID into rsp_id.
    - Set last_grant=N and go to ISSUE.
  - No valid: stay in IDLE; alu_* hold their previous values.
- ISSUE (1 cycle): alu_* stable; the ALU registers the result at the end of this cycle. Next state is CAPT.
- CAPT (1 cycle): latch alu_c -> rsp_c and alu_f -> rsp_f; set rsp_valid=1; go to RESP.
- RESP:
  - rsp_valid=1 and rsp_c/f/id held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid=0, ops_done+1, return to IDLE.
  - No new grant in the same cycle; next grant no earlier than the following cycle.
- Latency: request acceptance to rsp_valid is 3 clock edges. Minimum back-to-back spacing is 4 cycles.
- Requester contract: after reqN_ready, requesters may change their inputs. The scheduler never re-reads them for the in-flight operation.
- reqN_valid dropped while not granted: the request is withdrawn with no side effect.
- rsp_ready held high in CAPT: ignored. The handshake counts only in RESP.
- Arbitration is strictly alternating under continuous contention. No starvation: each requester waits at most one operation.
- ops_done wraps from 2^CNTW-1 to 0 silently.
- Opcodes are passed through unmodified. Undefined opcodes still complete; rsp_c/f carry whatever the ALU holds (its previous result).
- Reset mid-operation (any state): immediate return to reset values. The in-flight operation is lost and no response is produced.

Decomposition:
- Shared package/header: opcode constants (ADD, SUB, AND, OR, XOR, NOT), operand/opcode bus widths, flag bit indices (CARRY=2, OVF=1, ZERO=0), FSM state encodings.
- Sub-module rr_arb2: 2-input round-robin grant logic, with last_grant state inside it. Everything else stays in alu_rr_sched.

Test Plan:
- Reset: rst=0 mid-RESP with rsp_valid=1 -> all outputs 0 asynchronously; after release, state=IDLE and ops_done=0.
- Single ADD:
  - Stimulus: req0 ADD with A=30, B=40.
  - Required: req0_ready pulses, then 3 edges later rsp_valid=1, rsp_id=0, rsp_c=6, rsp_f=3'b100.
  - After rsp_ready, ops_done=1.
- SUB to zero: req1 SUB with A=5, B=5 -> rsp_id=1, rsp_c=0, rsp_f=3'b001.
- Contention: both valid continuously for 4 operations -> grant order 0,1,0,1; rsp_id sequence matches; ops_done=4.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_c/f/id stable, no reqN_ready pulses, busy=1; completes on the first cycle rsp_ready=1.
- Counter wrap: preload through 256 completed operations with CNTW=8 -> ops_done returns to 0 with no other effect.
